cordic_rr_arbiter: RTL and testbench

Shares a single `cordic_sincos` instance between up to `NUM_REQ` phase requesters, such as `processb` and other polar-to-Cartesian clients. Requests are granted round-robin, and each granted request is tagged with its requester index. Tags travel through an in-order tag FIFO that mirrors the CORDIC pipeline. Each CORDIC result is steered back to the requester that issued the matching phase.

---
 rtl/cordic_arb_pkg.sv | 24 ++
 rtl/cordic_tag_fifo.sv | 59 +++++
 rtl/cordic_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_cordic_rr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC round-robin arbiter.
//   PHASE_W     : width of one phase word (signed, 2^15 = 180 deg)
//   DOUT_W      : width of one CORDIC result ({cos, sin}, Q2.14 each)
//   req_tag_t   : requester index carried through the tag FIFO
//   arb_state_t : FLUSH / RUN
//   rr_next()   : round-robin successor of a requester index
package cordic_arb_pkg;

   localparam int PHASE_W = 16;
   localparam int DOUT_W  = 32;

   typedef logic [2:0] req_tag_t;

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_t;

   function automatic req_tag_t rr_next(input req_tag_t tag, input int num_req);
      if (int'(tag) >= num_req - 1) return '0;
      return tag + 3'd1;
   endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order tag FIFO that mirrors the CORDIC pipeline.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : head entry
//   full/empty : occupancy flags, derived from the registered count
//   count      : number of stored entries
module cordic_tag_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Depth need not be a power of two, so pointers wrap explicitly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Shares one CORDIC sin/cos core between NUM_REQ phase requesters.
// Requests are granted round-robin; the winner's index is queued in a tag
// FIFO and used to steer the matching CORDIC result back one cycle later.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FLUSH | after reset: no grants, CORDIC outputs dropped silently
//   ST_RUN   | normal arbitration and result steering until next reset
//
//   clk, rst_n                       : clock, async active-low reset
//   req_valid / req_phase / req_ready : per-requester phase handshake
//   rsp_valid / rsp_data              : one-hot result strobe, shared data
//   cordic_phase_valid/_data          : to the CORDIC phase input
//   cordic_dout_valid/_data           : from the CORDIC result output
//   outstanding, busy, err_orphan     : status
module cordic_rr_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int TAG_DEPTH    = 32,
   parameter int FLUSH_CYCLES = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*PHASE_W-1:0]     req_phase,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DOUT_W-1:0]              rsp_data,
   output logic                           cordic_phase_valid,
   output logic [PHASE_W-1:0]             cordic_phase_data,
   input  logic                           cordic_dout_valid,
   input  logic [DOUT_W-1:0]              cordic_dout_data,
   output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
   output logic                           busy,
   output logic                           err_orphan
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [FL_W-1:0]  flush_cnt;
   req_tag_t         rr_ptr;
   req_tag_t         gnt_tag;
   logic             gnt_found;
   int               idx;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [TAG_W-1:0] head_tag;
   logic [CNT_W-1:0] fifo_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_FLUSH;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      flush_cnt <= FL_W'(FLUSH_CYCLES);
      else if (state_q == ST_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
   end

   // Leave FLUSH on the same edge the counter lands on 0, so the first
   // grant can happen FLUSH_CYCLES cycles after reset release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FLUSH: if (flush_cnt <= FL_W'(1)) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // Search upward from rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_tag   = '0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_tag   = req_tag_t'(idx);
         end
      end
   end

   // Full check uses the registered count: a same-cycle pop never frees a slot.
   always_comb begin
      req_ready          = '0;
      cordic_phase_valid = 1'b0;
      cordic_phase_data  = '0;
      push               = 1'b0;
      if (state_q == ST_RUN && !fifo_full && gnt_found) begin
         req_ready          = NUM_REQ'(1) << gnt_tag;
         cordic_phase_valid = 1'b1;
         cordic_phase_data  = req_phase[int'(gnt_tag)*PHASE_W +: PHASE_W];
         push               = 1'b1;
      end
   end

   assign pop = (state_q == ST_RUN) && cordic_dout_valid && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (push) rr_ptr <= rr_next(gnt_tag, NUM_REQ);
         rsp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
         if (pop) rsp_data <= cordic_dout_data;
         if (state_q == ST_RUN && cordic_dout_valid && fifo_empty) err_orphan <= 1'b1;
      end
   end

   cordic_tag_fifo #(
      .W     (TAG_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (gnt_tag[TAG_W-1:0]),
      .pop       (pop),
      .pop_data  (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign outstanding = fifo_count;
   assign busy        = (state_q == ST_FLUSH) || (fifo_count != '0);

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a CORDIC stub of selectable
// latency. The stub echoes a phase p as {p, ~p}.
module tb_cordic_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [31:0] req_phase = '0;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        cordic_phase_valid;
   logic [15:0] cordic_phase_data;
   logic        cordic_dout_valid;
   logic [31:0] cordic_dout_data;
   logic [3:0]  outstanding;
   logic        busy;
   logic        err_orphan;

   int n_err = 0;
   int n_chk = 0;

   int          lat = 10;
   logic        inj_v = 1'b0;
   logic [31:0] inj_d = '0;
   logic [15:0] sv = '0;
   logic [15:0] sd [16];

   always #5 clk = ~clk;

   cordic_rr_arbiter #(
      .NUM_REQ      (2),
      .TAG_DEPTH    (8),
      .FLUSH_CYCLES (8)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_phase          (req_phase),
      .req_ready          (req_ready),
      .rsp_valid          (rsp_valid),
      .rsp_data           (rsp_data),
      .cordic_phase_valid (cordic_phase_valid),
      .cordic_phase_data  (cordic_phase_data),
      .cordic_dout_valid  (cordic_dout_valid),
      .cordic_dout_data   (cordic_dout_data),
      .outstanding        (outstanding),
      .busy               (busy),
      .err_orphan         (err_orphan)
   );

   // CORDIC stub: not reset, so stale results survive a DUT reset.
   always @(posedge clk) begin
      sv <= {sv[14:0], cordic_phase_valid};
      sd[0] <= cordic_phase_data;
      for (int i = 1; i < 16; i++) sd[i] <= sd[i-1];
   end

   assign cordic_dout_valid = sv[lat-1] | inj_v;
   assign cordic_dout_data  = inj_v ? inj_d : {sd[lat-1], ~sd[lat-1]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      logic [15:0] ph1 [3];
      logic [31:0] rd1 [3];
      logic [1:0]  vl3 [5];
      logic [1:0]  rd3 [5];
      logic [15:0] pd3 [5];
      logic [31:0] dd3 [5];
      logic [1:0]  exp_rv;

      ph1 = '{16'h0000, 16'h2000, 16'h4000};
      rd1 = '{32'h0000FFFF, 32'h2000DFFF, 32'h4000BFFF};
      vl3 = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
      rd3 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
      pd3 = '{16'h2222, 16'h1111, 16'h2222, 16'h1111, 16'h1111};
      dd3 = '{32'h2222DDDD, 32'h1111EEEE, 32'h2222DDDD, 32'h1111EEEE, 32'h1111EEEE};

      // ---- reset values and flush ----
      req_valid = 2'b11;
      req_phase = 32'h5555_6666;
      #1;
      chk("rst_ready",      32'(req_ready), 32'h0);
      chk("rst_rsp_valid",  32'(rsp_valid), 32'h0);
      chk("rst_rsp_data",   rsp_data, 32'h0);
      chk("rst_ph_valid",   32'(cordic_phase_valid), 32'h0);
      chk("rst_ph_data",    32'(cordic_phase_data), 32'h0);
      chk("rst_outstanding",32'(outstanding), 32'h0);
      chk("rst_busy",       32'(busy), 32'h1);
      chk("rst_orphan",     32'(err_orphan), 32'h0);
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 2'b01;
      inj_d     = 32'h1234_5678;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge clk);
         inj_v = (c < 5);
         #1;
         chk("flush_ready", 32'(req_ready), (c == 8) ? 32'h1 : 32'h0);
         chk("flush_rsp_valid", 32'(rsp_valid), 32'h0);
         if (c == 3) chk("flush_busy", 32'(busy), 32'h1);
      end
      chk("flush_orphan", 32'(err_orphan), 32'h0);
      chk("run_idle_busy", 32'(busy), 32'h0);
      #1 req_valid = 2'b00;

      // ---- single requester, latency 10 ----
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         req_valid = (c < 3) ? 2'b01 : 2'b00;
         if (c < 3) req_phase = {16'h0, ph1[c]};
         #1;
         if (c < 3) begin
            chk("single_ready", 32'(req_ready), 32'h1);
            chk("single_phase", 32'(cordic_phase_data), 32'(ph1[c]));
         end
         if (c == 3) chk("single_outstanding3", 32'(outstanding), 32'h3);
         exp_rv = (c >= 11 && c <= 13) ? 2'b01 : 2'b00;
         chk("single_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (c >= 11 && c <= 13) chk("single_rsp_data", rsp_data, rd1[c-11]);
         if (c == 14) begin
            chk("single_drained", 32'(outstanding), 32'h0);
            chk("single_busy", 32'(busy), 32'h0);
         end
      end

      // ---- contention (rr_ptr = 1 after the req0 stream), then wrap ----
      req_phase = 32'h2222_1111;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         req_valid = (c < 5) ? vl3[c] : 2'b00;
         #1;
         if (c < 5) begin
            chk("cont_ready", 32'(req_ready), 32'(rd3[c]));
            chk("cont_phase", 32'(cordic_phase_data), 32'(pd3[c]));
         end else begin
            chk("cont_idle_phv", 32'(cordic_phase_valid), 32'h0);
         end
         exp_rv = (c >= 11 && c <= 15) ? rd3[c-11] : 2'b00;
         chk("cont_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (c >= 11 && c <= 15) chk("cont_rsp_data", rsp_data, dd3[c-11]);
      end

      // ---- FIFO full, depth 8, latency 8 ----
      lat = 8;
      req_phase = 32'h0000_0ABC;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         req_valid = 2'b01;
         #1;
         chk("full_ready", 32'(req_ready), (c == 8) ? 32'h0 : 32'h1);
         if (c == 8) begin
            chk("full_peak", 32'(outstanding), 32'h8);
            chk("full_ph_valid", 32'(cordic_phase_valid), 32'h0);
            chk("full_ph_data", 32'(cordic_phase_data), 32'h0);
         end
         if (c == 9) chk("full_after_pop", 32'(outstanding), 32'h7);
      end
      @(negedge clk);
      req_valid = 2'b00;
      repeat (25) @(negedge clk);
      #1;
      chk("full_drained", 32'(outstanding), 32'h0);
      chk("full_no_orphan", 32'(err_orphan), 32'h0);

      // ---- orphan ----
      inj_d = 32'hDEAD_BEEF;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         inj_v = (c == 0);
         #1;
         chk("orphan_flag", 32'(err_orphan), (c == 0) ? 32'h0 : 32'h1);
         chk("orphan_rsp_valid", 32'(rsp_valid), 32'h0);
      end

      // ---- reset mid-stream with 6 tags outstanding ----
      lat = 10;
      req_phase = 32'h4444_3333;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 2'b11;
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("mid_outstanding6", 32'(outstanding), 32'h6);
      rst_n = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("mid_rst_outstanding", 32'(outstanding), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h1);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      chk("mid_rst_ph_valid", 32'(cordic_phase_valid), 32'h0);
      chk("mid_rst_ph_data", 32'(cordic_phase_data), 32'h0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_rst_rsp_data", rsp_data, 32'h0);
      chk("mid_rst_orphan", 32'(err_orphan), 32'h0);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         chk("stale_rsp_valid", 32'(rsp_valid), 32'h0);
      end
      chk("stale_orphan", 32'(err_orphan), 32'h0);
      chk("stale_busy", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
